// File: rtl/mux4_32_if.sv
// Bus bundle for the 4:1 mux: select, four data inputs, and the combinational and registered results.
// The master drives select and data; the slave returns the mux outputs.
interface mux4_32_if #(
  parameter int WIDTH = 32
);
  logic [1:0]       s;
  logic [WIDTH-1:0] d0;
  logic [WIDTH-1:0] d1;
  logic [WIDTH-1:0] d2;
  logic [WIDTH-1:0] d3;
  logic [WIDTH-1:0] y;
  logic [3:0]       sel_oh;
  logic [WIDTH-1:0] y_q;
  logic             chg;

  modport master (
    output s, d0, d1, d2, d3,
    input  y, sel_oh, y_q, chg
  );

  modport slave (
    input  s, d0, d1, d2, d3,
    output y, sel_oh, y_q, chg
  );
endinterface

// File: rtl/mux4_32.sv
// 4:1 WIDTH-bit mux with a one-hot select decode, a registered copy of the output,
// and a one-cycle pulse whenever the selected value differs from the registered copy.
module mux4_32 #(
  parameter int WIDTH = 32
) (
  input logic      clk,
  input logic      rst,
  mux4_32_if.slave bus
);

  logic [WIDTH-1:0] y_mux;
  logic [3:0]       sel_dec;

  // An undefined select propagates X rather than falling back to any input.
  always_comb begin
    y_mux   = 'x;
    sel_dec = 'x;
    case (bus.s)
      2'b00: begin y_mux = bus.d0; sel_dec = 4'b0001; end
      2'b01: begin y_mux = bus.d1; sel_dec = 4'b0010; end
      2'b10: begin y_mux = bus.d2; sel_dec = 4'b0100; end
      2'b11: begin y_mux = bus.d3; sel_dec = 4'b1000; end
      default: begin y_mux = 'x; sel_dec = 'x; end
    endcase
  end

  assign bus.y      = y_mux;
  assign bus.sel_oh = sel_dec;

  // chg compares the incoming value against the copy still held in y_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.y_q <= '0;
      bus.chg <= 1'b0;
    end else begin
      bus.y_q <= y_mux;
      bus.chg <= (y_mux != bus.y_q);
    end
  end

endmodule

// File: tb/tb_mux4_32.sv
// Scoreboard bench for mux4_32: stimulus pushes expected results into a queue,
// and a monitor on the falling edge pops and compares them against the DUT.
module tb_mux4_32;

  localparam int WIDTH = 32;

  typedef struct packed {
    logic             check_reg;
    logic [WIDTH-1:0] y;
    logic [3:0]       sel;
    logic [WIDTH-1:0] yq;
    logic             chg;
  } exp_t;

  logic clk;
  logic rst;

  mux4_32_if #(.WIDTH(WIDTH)) bus ();

  mux4_32 #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t sb[$];
  int   vectors_applied = 0;
  int   miscompares     = 0;

  // Reference state: the value y_q and chg should hold, derived from what was applied last cycle.
  logic [WIDTH-1:0] ref_yq;
  logic             ref_chg;
  logic [WIDTH-1:0] prev_y;
  logic             prev_rst;
  logic             ref_known = 1'b0;
  logic             have_prev = 1'b0;

  task automatic applyStimulus(input logic r, input logic [1:0] sel,
                               input logic [WIDTH-1:0] a0, input logic [WIDTH-1:0] a1,
                               input logic [WIDTH-1:0] a2, input logic [WIDTH-1:0] a3);
    logic [WIDTH-1:0] data [4];
    exp_t e;
    @(posedge clk);
    if (have_prev) begin
      if (prev_rst) begin
        ref_yq    = '0;
        ref_chg   = 1'b0;
        ref_known = 1'b1;
      end else if (ref_known) begin
        ref_chg = (prev_y != ref_yq);
        ref_yq  = prev_y;
      end
    end
    #1;
    rst    = r;
    bus.s  = sel;
    bus.d0 = a0;
    bus.d1 = a1;
    bus.d2 = a2;
    bus.d3 = a3;
    data[0] = a0;
    data[1] = a1;
    data[2] = a2;
    data[3] = a3;
    e.check_reg = ref_known;
    e.y         = data[sel];
    e.sel       = 4'b0001 << sel;
    e.yq        = ref_yq;
    e.chg       = ref_chg;
    sb.push_back(e);
    prev_y    = data[sel];
    prev_rst  = r;
    have_prev = 1'b1;
  endtask

  task automatic checkOutput(input exp_t e);
    vectors_applied++;
    if (bus.y !== e.y) begin
      miscompares++;
      $display("[TB] FAIL y: got %h want %h (s=%b)", bus.y, e.y, bus.s);
    end
    if (bus.sel_oh !== e.sel) begin
      miscompares++;
      $display("[TB] FAIL sel_oh: got %b want %b (s=%b)", bus.sel_oh, e.sel, bus.s);
    end
    if (e.check_reg) begin
      if (bus.y_q !== e.yq) begin
        miscompares++;
        $display("[TB] FAIL y_q: got %h want %h", bus.y_q, e.yq);
      end
      if (bus.chg !== e.chg) begin
        miscompares++;
        $display("[TB] FAIL chg: got %b want %b", bus.chg, e.chg);
      end
    end
  endtask

  // Monitor: the DUT presents one result per cycle, sampled half a cycle after inputs settle.
  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) checkOutput(sb.pop_front());
    end
  end

  logic [WIDTH-1:0] walk;

  initial begin
    rst    = 1'b1;
    bus.s  = 2'b00;
    bus.d0 = '0;
    bus.d1 = '0;
    bus.d2 = '0;
    bus.d3 = '0;

    // Reset held two cycles, then release with d1 selected.
    applyStimulus(1'b1, 2'b01, 32'h0, 32'hDEADBEEF, 32'h0, 32'h0);
    applyStimulus(1'b1, 2'b01, 32'h0, 32'hDEADBEEF, 32'h0, 32'h0);
    applyStimulus(1'b0, 2'b01, 32'h0, 32'hDEADBEEF, 32'h0, 32'h0);
    applyStimulus(1'b0, 2'b01, 32'h0, 32'hDEADBEEF, 32'h0, 32'h0);
    applyStimulus(1'b0, 2'b01, 32'h0, 32'hDEADBEEF, 32'h0, 32'h0);

    for (int k = 0; k < 4; k++)
      applyStimulus(1'b0, 2'(k), 32'h00000000, 32'hFFFFFFFF, 32'hAAAAAAAA, 32'h55555555);

    for (int k = 0; k < 8; k++)
      applyStimulus(1'b0, 2'b10, $urandom, $urandom, 32'h12345678, $urandom);

    for (int k = 0; k < 4; k++) begin
      for (int b = 0; b < WIDTH; b++) begin
        walk = '0;
        walk[b] = 1'b1;
        applyStimulus(1'b0, 2'(k),
                      (k == 0) ? walk : ~walk, (k == 1) ? walk : ~walk,
                      (k == 2) ? walk : ~walk, (k == 3) ? walk : ~walk);
      end
    end

    // Mid-stream reset with a known value held in y_q.
    applyStimulus(1'b0, 2'b00, 32'hCAFEF00D, $urandom, $urandom, $urandom);
    applyStimulus(1'b0, 2'b00, 32'hCAFEF00D, $urandom, $urandom, $urandom);
    applyStimulus(1'b1, 2'b00, 32'hCAFEF00D, $urandom, $urandom, $urandom);
    applyStimulus(1'b0, 2'b00, 32'hCAFEF00D, $urandom, $urandom, $urandom);
    applyStimulus(1'b0, 2'b00, 32'hCAFEF00D, $urandom, $urandom, $urandom);
    applyStimulus(1'b0, 2'b00, 32'hCAFEF00D, $urandom, $urandom, $urandom);

    for (int k = 0; k < 300; k++)
      applyStimulus(($urandom_range(0, 15) == 0), 2'($urandom_range(0, 3)),
                    $urandom, $urandom, $urandom, $urandom);

    // Bounded drain of the scoreboard.
    for (int k = 0; k < 4 && sb.size() > 0; k++) @(negedge clk);
    @(posedge clk);
    if (sb.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL drain: got %0d pending want 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
